// File: rtl/comparator_tree_pipe_pkg.sv
// comparator_tree_pkg: node type, node combine function and tree geometry helpers
// No ports. Defaults describe the WIDTH=64, PIPE_EVERY=2 build.
package comparator_tree_pkg;
  typedef struct packed {
    logic eq;
    logic lt;
  } cmp_node_t;
  localparam int WIDTH_DEF = 64;
  localparam int PIPE_EVERY_DEF = 2;
  function automatic int log2w(input int width);
    return $clog2(width);
  endfunction
  function automatic int nstage(input int width, input int pipe_every);
    return ($clog2(width) + pipe_every - 1) / pipe_every;
  endfunction
  localparam int LOG2W = log2w(WIDTH_DEF);
  localparam int NSTAGE = nstage(WIDTH_DEF, PIPE_EVERY_DEF);
  function automatic cmp_node_t cmp_combine(input cmp_node_t hi, input cmp_node_t lo);
    return '{eq: hi.eq & lo.eq, lt: hi.lt | (hi.eq & lo.lt)};
  endfunction
endpackage

// File: rtl/comparator_tree_pipe_if.sv
// comparator_tree_pipe_if: operand/result handshake bundle for comparator_tree_pipe
// master drives in_valid/op1/op2/in_tag/out_ready; slave drives in_ready/out_valid/EQ/LT/LTu/out_tag.
interface comparator_tree_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic EQ;
  logic LT;
  logic LTu;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, op1, op2, in_tag, out_ready,
    input in_ready, out_valid, EQ, LT, LTu, out_tag
  );
  modport slave (
    input in_valid, op1, op2, in_tag, out_ready,
    output in_ready, out_valid, EQ, LT, LTu, out_tag
  );
endinterface

// File: rtl/comparator_tree_pipe_level.sv
// cmp_tree_level: one combinational tree level reducing N nodes to N/2
// in_nodes: N nodes, index 2i+1 is the more significant of each pair; out_nodes: N/2 nodes.
module cmp_tree_level import comparator_tree_pkg::*; #(
  parameter int N = 2
) (
  input cmp_node_t [N-1:0] in_nodes,
  output cmp_node_t [N/2-1:0] out_nodes
);
  always_comb
    for (int i = 0; i < N / 2; i++) out_nodes[i] = cmp_combine(in_nodes[2*i+1], in_nodes[2*i]);
endmodule

// File: rtl/comparator_tree_pipe.sv
// comparator_tree_pipe: pipelined EQ / signed LT / unsigned LTu comparator tree with valid/ready
// Ports: clk, reset (async, active-high), bus (slave modport of comparator_tree_pipe_if).
module comparator_tree_pipe import comparator_tree_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic reset,
  comparator_tree_pipe_if.slave bus
);
  localparam int LVLS = log2w(WIDTH);
  localparam int STAGES = nstage(WIDTH, PIPE_EVERY);
  localparam int SBW = TAG_W + 3;
  logic adv;
  logic out_valid_q, out_valid_d, eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  // sideband chain {valid, op1 msb, op2 msb, tag}; index = registers passed
  logic [STAGES-1:0][SBW-1:0] sb;
  logic [SBW-1:0] sb_last;
  cmp_node_t root;
  // the whole pipe moves together; bubbles are carried, not squeezed out
  assign adv = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = adv;
  assign sb[0] = {bus.in_valid, bus.op1[WIDTH-1], bus.op2[WIDTH-1], bus.in_tag};
  for (genvar s = 1; s < STAGES; s++) begin : g_sb
    logic [SBW-1:0] sb_d, sb_q;
    always_comb sb_d = adv ? sb[s-1] : sb_q;
    always_ff @(posedge clk or posedge reset)
      if (reset) sb_q <= '0;
      else sb_q <= sb_d;
    assign sb[s] = sb_q;
  end
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    cmp_node_t [N-1:0] lin;
    cmp_node_t [N/2-1:0] lout, lres;
    if (l == 0) begin : g_leaf
      always_comb
        for (int i = 0; i < WIDTH; i++) lin[i] = {~(bus.op1[i] ^ bus.op2[i]), ~bus.op1[i] & bus.op2[i]};
    end else begin : g_link
      assign lin = g_lvl[l-1].lres;
    end
    cmp_tree_level #(.N(N)) u_level (.in_nodes(lin), .out_nodes(lout));
    // the last level feeds the output registers instead of a stage register
    if ((l + 1) % PIPE_EVERY == 0 && l != LVLS - 1) begin : g_reg
      cmp_node_t [N/2-1:0] node_d, node_q;
      always_comb node_d = adv ? lout : node_q;
      always_ff @(posedge clk) node_q <= node_d;
      assign lres = node_q;
    end else begin : g_pass
      assign lres = lout;
    end
  end
  assign sb_last = sb[STAGES-1];
  assign root = g_lvl[LVLS-1].lres[0];
  // differing sign bits decide signed order on their own: the negative operand is smaller
  always_comb begin
    out_valid_d = adv ? sb_last[SBW-1] : out_valid_q;
    eq_d = adv ? root.eq : eq_q;
    ltu_d = adv ? root.lt : ltu_q;
    lt_d = adv ? ((sb_last[SBW-2] ^ sb_last[SBW-3]) ? sb_last[SBW-2] : root.lt) : lt_q;
    tag_d = adv ? sb_last[TAG_W-1:0] : tag_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
      ltu_q <= 1'b0;
      tag_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
      ltu_q <= ltu_d;
      tag_q <= tag_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.EQ = eq_q;
  assign bus.LT = lt_q;
  assign bus.LTu = ltu_q;
  assign bus.out_tag = tag_q;
endmodule

// File: tb/tb_comparator_tree_pipe.sv
// tb_comparator_tree_pipe: directed and random checks of comparator_tree_pipe at PIPE_EVERY 2, 1 and 6
module tb_comparator_tree_pipe;
  localparam int W = 64;
  localparam int TW = 4;
  localparam int NV = 8192;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  comparator_tree_pipe_if #(.WIDTH(W), .TAG_W(TW)) b2 ();
  comparator_tree_pipe_if #(.WIDTH(W), .TAG_W(TW)) b1 ();
  comparator_tree_pipe_if #(.WIDTH(W), .TAG_W(TW)) b6 ();
  comparator_tree_pipe #(.WIDTH(W), .PIPE_EVERY(2), .TAG_W(TW)) u2 (.clk(clk), .reset(reset), .bus(b2));
  comparator_tree_pipe #(.WIDTH(W), .PIPE_EVERY(1), .TAG_W(TW)) u1 (.clk(clk), .reset(reset), .bus(b1));
  comparator_tree_pipe #(.WIDTH(W), .PIPE_EVERY(6), .TAG_W(TW)) u6 (.clk(clk), .reset(reset), .bus(b6));
  logic [7:0] o2, o1, o6;
  assign o2 = {b2.out_valid, b2.EQ, b2.LT, b2.LTu, b2.out_tag};
  assign o1 = {b1.out_valid, b1.EQ, b1.LT, b1.LTu, b1.out_tag};
  assign o6 = {b6.out_valid, b6.EQ, b6.LT, b6.LTu, b6.out_tag};
  logic [7:0] q1[$], q6[$];
  logic [7:0] stream_exp [4] = '{8'b1011_0000, 8'b1011_0001, 8'b1100_0010, 8'b1000_0011};
  logic [63:0] a, b;
  int n1 = 0, n6 = 0, r1 = 0, r6 = 0;

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive2(input logic v, input logic [63:0] x, input logic [63:0] y, input logic [3:0] t);
    b2.in_valid = v;
    b2.op1 = x;
    b2.op2 = y;
    b2.in_tag = t;
  endtask

  task automatic one(input string name, input logic [63:0] x, input logic [63:0] y, input logic [3:0] t, input logic [7:0] exp);
    drive2(1'b1, x, y, t);
    tick;
    b2.in_valid = 1'b0;
    check({name, "_lat1"}, 8'(o2[7]), 8'd0);
    tick;
    check({name, "_lat2"}, 8'(o2[7]), 8'd0);
    tick;
    check(name, o2, exp);
  endtask

  task automatic pick(output logic [63:0] x, output logic [63:0] y);
    int m;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    m = $urandom_range(0, 3);
    y = m == 0 ? x : m == 1 ? x ^ (64'd1 << $urandom_range(0, 63)) : y;
  endtask

  function automatic logic [7:0] model(input logic [63:0] x, input logic [63:0] y, input logic [3:0] t);
    return {1'b1, x == y, $signed(x) < $signed(y), x < y, t};
  endfunction

  initial begin
    drive2(1'b0, '0, '0, '0);
    b2.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.op1 = '0; b1.op2 = '0; b1.in_tag = '0; b1.out_ready = 1'b1;
    b6.in_valid = 1'b0; b6.op1 = '0; b6.op2 = '0; b6.in_tag = '0; b6.out_ready = 1'b1;
    repeat (2) tick;
    check("reset_outputs", o2, 8'h00);
    check("reset_in_ready", 8'(b2.in_ready), 8'd1);
    reset = 1'b0;
    tick;
    check("idle_outputs", 8'(o2[7]), 8'd0);
    one("equal", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 4'd5, 8'b1100_0101);
    one("neg_vs_one", 64'hFFFFFFFFFFFFFFFF, 64'h1, 4'd6, 8'b1010_0110);
    one("one_vs_neg", 64'h1, 64'hFFFFFFFFFFFFFFFF, 4'd7, 8'b1001_0111);
    one("min_vs_max", 64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 4'd1, 8'b1010_0001);
    one("lsb_diff", 64'h2, 64'h3, 4'd2, 8'b1011_0010);
    for (int c = 0; c < 7; c++) begin
      drive2(c < 4, 64'(c), 64'h2, 4'(c));
      tick;
      if (c >= 2 && c < 6) check("stream", o2, stream_exp[c-2]);
      else check("stream_bubble", 8'(o2[7]), 8'd0);
    end
    drive2(1'b1, 64'h10, 64'h10, 4'd8);
    tick;
    drive2(1'b1, 64'h8000000000000000, 64'h0, 4'd9);
    tick;
    drive2(1'b1, 64'h0, 64'h8000000000000000, 4'd10);
    tick;
    check("bp_head", o2, 8'b1100_1000);
    b2.out_ready = 1'b0;
    drive2(1'b1, 64'h5, 64'h7FFFFFFFFFFFFFFF, 4'd11);
    #1;
    check("bp_in_ready", 8'(b2.in_ready), 8'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      check("bp_hold", o2, 8'b1100_1000);
      check("bp_in_ready_hold", 8'(b2.in_ready), 8'd0);
    end
    b2.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 8'(b2.in_ready), 8'd1);
    tick;
    b2.in_valid = 1'b0;
    check("bp_out9", o2, 8'b1010_1001);
    tick;
    check("bp_out10", o2, 8'b1001_1010);
    tick;
    check("bp_out11", o2, 8'b1011_1011);
    tick;
    check("bp_drained", 8'(o2[7]), 8'd0);
    b1.in_valid = 1'b1; b1.op1 = 64'hA; b1.op2 = 64'hB; b1.in_tag = 4'd3;
    b6.in_valid = 1'b1; b6.op1 = 64'hFFFFFFFF00000000; b6.op2 = 64'hFFFFFFFF00000000; b6.in_tag = 4'd9;
    for (int k = 1; k <= 6; k++) begin
      tick;
      b1.in_valid = 1'b0;
      b6.in_valid = 1'b0;
      if (k == 1) check("p6_latency1", o6, 8'b1100_1001);
      check("p1_valid", 8'(o1[7]), 8'(k == 6));
    end
    check("p1_latency6", o1, 8'b1011_0011);
    for (int k = 12; k < 15; k++) begin
      drive2(1'b1, 64'h0, 64'h0, 4'(k));
      tick;
    end
    b2.in_valid = 1'b0;
    check("pre_reset_head", o2, 8'b1100_1100);
    reset = 1'b1;
    #1;
    check("async_reset_out", o2, 8'h00);
    check("async_reset_ready", 8'(b2.in_ready), 8'd1);
    tick;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("post_reset_empty", 8'(o2[7]), 8'd0);
    end
    for (int cyc = 0; cyc < 40000 && (r1 < NV || r6 < NV); cyc++) begin
      b1.out_ready = $urandom_range(0, 3) != 0;
      b1.in_valid = n1 < NV && $urandom_range(0, 4) != 0;
      pick(a, b);
      b1.op1 = a; b1.op2 = b; b1.in_tag = 4'($urandom);
      b6.out_ready = $urandom_range(0, 3) != 0;
      b6.in_valid = n6 < NV && $urandom_range(0, 4) != 0;
      pick(a, b);
      b6.op1 = a; b6.op2 = b; b6.in_tag = 4'($urandom);
      #1;
      if (b1.in_valid && b1.in_ready) begin
        q1.push_back(model(b1.op1, b1.op2, b1.in_tag));
        n1++;
      end
      if (b6.in_valid && b6.in_ready) begin
        q6.push_back(model(b6.op1, b6.op2, b6.in_tag));
        n6++;
      end
      if (b1.out_valid && b1.out_ready) begin
        check("p1_expected_pending", 8'(q1.size() != 0), 8'd1);
        if (q1.size() != 0) check("p1_random", o1, q1.pop_front());
        r1++;
      end
      if (b6.out_valid && b6.out_ready) begin
        check("p6_expected_pending", 8'(q6.size() != 0), 8'd1);
        if (q6.size() != 0) check("p6_random", o6, q6.pop_front());
        r6++;
      end
      @(posedge clk);
      #2;
    end
    check("p1_result_count", 8'(r1 == NV), 8'd1);
    check("p6_result_count", 8'(r6 == NV), 8'd1);
    check("p1_queue_empty", 8'(q1.size()), 8'd0);
    check("p6_queue_empty", 8'(q6.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
